// File: rtl/issue_control.sv
// issue_control: decode/issue sequencer with a read-after-write scoreboard and a HALT state.
// Define ISSUE_PERF_EN to add the issue_cnt / stall_cnt performance counters.
module issue_control #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        instr_ready,
  input  logic        resume,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [1:0]  aluctr,
  output logic        s2ctr,
  output logic        we,
  output logic [3:0]  rdest_r,
  output logic [15:0] im16,
  output logic        halted,
  output logic        err_illegal
`ifdef ISSUE_PERF_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e state_q, state_d;

  logic [3:0]  op_s, rd_s, rs_s;
  logic [7:0]  imm8_s;
  logic        is_alu_s, is_ldi_s, is_halt_s, is_ill_s;
  logic        hazard_s, xfer_s, halted_d;

  logic [3:0]  ra_q, ra_d, rb_q, rb_d, rdest_q, rdest_d;
  logic [1:0]  aluctr_q, aluctr_d;
  logic        s2ctr_q, s2ctr_d, we_q, we_d, halted_q, err_q, err_d;
  logic [15:0] im16_q, im16_d;

  logic [PIPE_DEPTH-1:0]      sb_v_q, sb_v_d;
  logic [PIPE_DEPTH-1:0][3:0] sb_reg_q, sb_reg_d;

  assign op_s   = instr_data[15:12];
  assign rd_s   = instr_data[11:8];
  assign rs_s   = instr_data[7:4];
  assign imm8_s = instr_data[7:0];
  assign xfer_s = instr_valid & instr_ready;

  // Opcode class decode of the candidate word
  always_comb begin
    is_alu_s  = 1'b0;
    is_ldi_s  = 1'b0;
    is_halt_s = 1'b0;
    is_ill_s  = 1'b0;
    case (op_s)
      4'h0:                      is_alu_s  = 1'b0;
      4'h1, 4'h2, 4'h3, 4'h4:    is_alu_s  = 1'b1;
      4'h8:                      is_ldi_s  = 1'b1;
      4'hF:                      is_halt_s = 1'b1;
      default:                   is_ill_s  = 1'b1;
    endcase
  end

  // Only ALU ops read registers, so only they can collide with a pending write
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      hazard_s = hazard_s | (sb_v_q[i] & ((sb_reg_q[i] == rd_s) | (sb_reg_q[i] == rs_s)));
    end
    hazard_s = hazard_s & is_alu_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (xfer_s && is_halt_s) state_d = ST_HALTED;
        else                     state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
        else        state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs; ready is held low while rst is asserted so every output reads 0
  always_comb begin
    instr_ready = (state_q == ST_RUN) & ~hazard_s & ~rst;
    halted_d    = (state_d == ST_HALTED);
  end

  // Decode of the transferred word and scoreboard shift
  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    aluctr_d = aluctr_q;
    rdest_d  = rdest_q;
    im16_d   = im16_q;
    err_d    = err_q;
    we_d     = 1'b0;
    s2ctr_d  = 1'b0;
    if (xfer_s) begin
      if (is_alu_s) begin
        we_d     = 1'b1;
        aluctr_d = op_s[1:0] - 2'd1;
        rdest_d  = rd_s;
        ra_d     = rd_s;
        rb_d     = rs_s;
      end else if (is_ldi_s) begin
        we_d     = 1'b1;
        s2ctr_d  = 1'b1;
        aluctr_d = 2'b00;
        rdest_d  = rd_s;
        im16_d   = {{8{imm8_s[7]}}, imm8_s};
      end else if (is_ill_s) begin
        err_d    = 1'b1;
      end else begin
        err_d    = err_q;
      end
    end else begin
      err_d = err_q;
    end
    sb_v_d[0]   = we_d;
    sb_reg_d[0] = rdest_d;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      sb_v_d[i]   = sb_v_q[i-1];
      sb_reg_d[i] = sb_reg_q[i-1];
    end
  end

  // Registered issue outputs and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      aluctr_q <= 2'd0;
      s2ctr_q  <= 1'b0;
      we_q     <= 1'b0;
      rdest_q  <= 4'd0;
      im16_q   <= 16'd0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      sb_v_q   <= '0;
      sb_reg_q <= '0;
    end else begin
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      aluctr_q <= aluctr_d;
      s2ctr_q  <= s2ctr_d;
      we_q     <= we_d;
      rdest_q  <= rdest_d;
      im16_q   <= im16_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      sb_v_q   <= sb_v_d;
      sb_reg_q <= sb_reg_d;
    end
  end

  assign ra_addr     = ra_q;
  assign rb_addr     = rb_q;
  assign aluctr      = aluctr_q;
  assign s2ctr       = s2ctr_q;
  assign we          = we_q;
  assign rdest_r     = rdest_q;
  assign im16        = im16_q;
  assign halted      = halted_q;
  assign err_illegal = err_q;

`ifdef ISSUE_PERF_EN
  logic [15:0] issue_cnt_q, stall_cnt_q;

  // Performance counters, both wrap naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      issue_cnt_q <= issue_cnt_q + {15'd0, we_d};
      stall_cnt_q <= stall_cnt_q + {15'd0, (instr_valid & (state_q == ST_RUN) & hazard_s)};
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_control.sv
// Self-checking bench for issue_control: directed scenarios plus randomized traffic
// checked against a cycle-age model of pending register writes.
module tb_issue_control;
  localparam int PD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'd0;
  logic        resume = 1'b0;
  logic        instr_ready;
  logic [3:0]  ra_addr, rb_addr, rdest_r;
  logic [1:0]  aluctr;
  logic        s2ctr, we, halted, err_illegal;
  logic [15:0] im16;
`ifdef ISSUE_PERF_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  issue_control #(.PIPE_DEPTH(PD)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .resume      (resume),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .aluctr      (aluctr),
    .s2ctr       (s2ctr),
    .we          (we),
    .rdest_r     (rdest_r),
    .im16        (im16),
    .halted      (halted),
    .err_illegal (err_illegal)
`ifdef ISSUE_PERF_EN
    ,
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a register is pending while fewer than PD+1 edges have
  // passed since the edge that issued a write to it.
  int          cyc;
  int          last_wr [16];
  bit          m_halted, m_err, m_we, m_s2;
  logic [1:0]  m_alu;
  logic [3:0]  m_ra, m_rb, m_rd;
  logic [15:0] m_im, m_issue, m_stall;
  bit          last_ready_obs;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) last_wr[i] = -100;
    cyc = 0;
    m_halted = 1'b0; m_err = 1'b0; m_we = 1'b0; m_s2 = 1'b0;
    m_alu = 2'd0; m_ra = 4'd0; m_rb = 4'd0; m_rd = 4'd0; m_im = 16'd0;
    m_issue = 16'd0; m_stall = 16'd0;
  endtask

  function automatic bit pend(input logic [3:0] r);
    return (cyc - last_wr[r]) <= PD;
  endfunction

  task automatic check_outputs();
    chk("we", {15'd0, we}, {15'd0, m_we});
    chk("s2ctr", {15'd0, s2ctr}, {15'd0, m_s2});
    chk("aluctr", {14'd0, aluctr}, {14'd0, m_alu});
    chk("rdest_r", {12'd0, rdest_r}, {12'd0, m_rd});
    chk("ra_addr", {12'd0, ra_addr}, {12'd0, m_ra});
    chk("rb_addr", {12'd0, rb_addr}, {12'd0, m_rb});
    chk("im16", im16, m_im);
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("err_illegal", {15'd0, err_illegal}, {15'd0, m_err});
`ifdef ISSUE_PERF_EN
    chk("issue_cnt", issue_cnt, m_issue);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic check_zero();
    chk("rst_ready", {15'd0, instr_ready}, 16'd0);
    chk("rst_we", {15'd0, we}, 16'd0);
    chk("rst_s2ctr", {15'd0, s2ctr}, 16'd0);
    chk("rst_aluctr", {14'd0, aluctr}, 16'd0);
    chk("rst_rdest", {12'd0, rdest_r}, 16'd0);
    chk("rst_ra", {12'd0, ra_addr}, 16'd0);
    chk("rst_rb", {12'd0, rb_addr}, 16'd0);
    chk("rst_im16", im16, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err_illegal}, 16'd0);
`ifdef ISSUE_PERF_EN
    chk("rst_issue_cnt", issue_cnt, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
  endtask

  // Called at a falling edge; asserts rst between edges and releases it on the next falling edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check ready, predict, check after the rising edge
  task automatic step(input logic v, input logic [15:0] d, input logic res);
    logic [3:0] op, rd, rs;
    bit alu, haz, rdy, xfer;
    instr_valid = v;
    instr_data  = d;
    resume      = res;
    op = d[15:12];
    rd = d[11:8];
    rs = d[7:4];
    alu = (op >= 4'd1) && (op <= 4'd4);
    haz = alu && (pend(rd) || pend(rs));
    rdy = !m_halted && !haz;
    #1;
    last_ready_obs = instr_ready;
    chk("instr_ready", {15'd0, instr_ready}, {15'd0, rdy});
    xfer = v && rdy;
    if (v && !m_halted && haz) m_stall = m_stall + 16'd1;
    m_we = 1'b0;
    m_s2 = 1'b0;
    if (xfer) begin
      if (alu) begin
        m_we = 1'b1; m_alu = 2'(op - 4'd1);
        m_rd = rd; m_ra = rd; m_rb = rs;
        last_wr[rd] = cyc;
      end else if (op == 4'h8) begin
        m_we = 1'b1; m_s2 = 1'b1; m_alu = 2'd0; m_rd = rd;
        m_im = {{8{d[7]}}, d[7:0]};
        last_wr[rd] = cyc;
      end else if (op == 4'hF) begin
        m_halted = 1'b1;
      end else if (op != 4'h0) begin
        m_err = 1'b1;
      end
      if (m_we) m_issue = m_issue + 16'd1;
    end else if (m_halted && res) begin
      m_halted = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    cyc++;
    @(negedge clk);
  endtask

  logic [3:0] optab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h1,
                             4'h2, 4'h3, 4'h4, 4'h8, 4'hF, 4'h9, 4'h5};

  initial begin
    int stalls;
    bit done;
    logic [15:0] w;
    logic [3:0] opr;

    model_reset();
    #1 rst = 1'b1;
    #1 check_zero();
    @(negedge clk);
    rst = 1'b0;

    // LDI r3,0x85 then idle
    step(1'b1, 16'h8385, 1'b0);
    chk("ldi_im16", im16, 16'hFF85);
    chk("ldi_we", {15'd0, we}, 16'd1);
    step(1'b0, 16'h0000, 1'b0);
    chk("idle_we", {15'd0, we}, 16'd0);

    // Independent ADD r1,r2 / SUB r4,r5 back-to-back
    step(1'b1, 16'h1120, 1'b0);
    chk("add_ready", {15'd0, last_ready_obs}, 16'd1);
    chk("add_ra_rb", {8'd0, ra_addr, rb_addr}, 16'h0012);
    step(1'b1, 16'h2450, 1'b0);
    chk("sub_ready", {15'd0, last_ready_obs}, 16'd1);
    chk("sub_alu", {14'd0, aluctr}, 16'd1);
    chk("sub_ra_rb", {8'd0, ra_addr, rb_addr}, 16'h0045);
    step(1'b0, 16'h0000, 1'b0);

    // LDI r2,0x01 then dependent ADD r1,r2: two-cycle stall
    do_reset();
    step(1'b1, 16'h8201, 1'b0);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      step(1'b1, 16'h1120, 1'b0);
      if (last_ready_obs) done = 1'b1;
      else stalls++;
    end
    chk("raw_stall_cycles", 16'(stalls), 16'd2);
    chk("raw_add_alu", {14'd0, aluctr}, 16'd0);
    chk("raw_add_rdest", {12'd0, rdest_r}, 16'd1);
`ifdef ISSUE_PERF_EN
    chk("perf_issue_cnt", issue_cnt, 16'd2);
    chk("perf_stall_cnt", stall_cnt, 16'd2);
`endif

    // HALT, ADD held for 10 cycles, resume pulse, ADD accepted next edge
    step(1'b1, 16'hF000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h1110, 1'b0);
      chk("halt_hold_ready", {15'd0, last_ready_obs}, 16'd0);
    end
    chk("halt_halted", {15'd0, halted}, 16'd1);
    step(1'b1, 16'h1110, 1'b1);
    step(1'b1, 16'h1110, 1'b0);
    chk("resume_accept", {15'd0, last_ready_obs}, 16'd1);
    chk("resume_we", {15'd0, we}, 16'd1);

    // Illegal opcode is sticky
    step(1'b1, 16'h9000, 1'b0);
    chk("ill_we", {15'd0, we}, 16'd0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h8455, 1'b0);
    chk("ill_sticky", {15'd0, err_illegal}, 16'd1);

    // Reset in the middle of HALT
    step(1'b1, 16'hF000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    do_reset();
    step(1'b1, 16'h1110, 1'b0);
    chk("post_rst_accept", {15'd0, last_ready_obs}, 16'd1);

    // Randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(1'b1, 16'h8101, 1'b0);
        do_reset();
      end
      opr = optab[$urandom_range(13, 0)];
      w = {opr, 2'b00, 2'($urandom_range(3, 0)), 2'b00, 2'($urandom_range(3, 0)), 4'($urandom)};
      step(1'($urandom_range(3, 0) != 0), w, 1'($urandom_range(2, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/issue_control.md
Name: issue_control

Overview:
- Decode/issue sequencer for the 16-bit execution datapath.
- Accepts instruction words over a valid/ready handshake and decodes them into the execution-stage controls: aluctr, s2ctr, we, destination and immediate.
- Drives register-file read addresses.
- Tracks in-flight writes in a scoreboard and inserts bubbles on read-after-write hazards. A HALT state freezes issue.

Parameters:
- PIPE_DEPTH, 2: cycles an issued write stays pending in the scoreboard (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instr_valid  in  1  instr_data is valid.
- instr_data  in  16  instruction word: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm8.
- instr_ready  out  1  block accepts instr_data this cycle.
- resume  in  1  leaves HALTED.
- ra_addr  out  4  read address for rd operand (ALU ina).
- rb_addr  out  4  read address for rs operand (ALU inb).
- aluctr  out  2  ALU op.
- s2ctr  out  1  1 = write-back immediate, 0 = ALU result.
- we  out  1  write enable for issued instruction; 0 = bubble.
- rdest_r  out  4  destination register.
- im16  out  16  sign-extended imm8.
- halted  out  1  FSM in HALTED.
- err_illegal  out  1  sticky: illegal opcode seen.

Behaviour:
- Reset (async): all outputs 0. FSM RUN, scoreboard empty, err_illegal 0.
- Transfer occurs when instr_valid & instr_ready at a rising clk. All decode outputs are registered, so they are valid after the accepting edge (latency 1).
- Opcodes:
  - 0 NOP: we=0.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: aluctr = 00/01/10/11, s2ctr=0, we=1, rdest_r=rd, ra_addr=rd, rb_addr=rs. Result is rd := rd op rs.
  - 8 LDI: s2ctr=1, we=1, rdest_r=rd, im16 = {{8{imm8[7]}}, imm8}, aluctr=00.
  - F HALT: we=0; FSM goes to HALTED.
  - Any other opcode: we=0, err_illegal set. It is cleared only by rst.
- Any cycle with no transfer, and any NOP/HALT/illegal cycle, issues a bubble: we=0, s2ctr=0. The other outputs hold their last values.
- Scoreboard:
  - Shift register of PIPE_DEPTH entries {v, reg}. Each cycle, entry 0 loads the issued {we, rdest_r} and the remaining entries shift by one.
  - Hazard = the candidate is an ALU op and rd or rs equals reg of any valid entry. LDI, NOP and HALT never hazard.
  - instr_ready = RUN & !hazard. Hazard is evaluated combinationally on instr_data, regardless of instr_valid.
  - With PIPE_DEPTH=2, an ALU op depending on the previous instruction's destination stalls 2 cycles.
- FSM:
  - RUN -> HALTED on accepted HALT.
  - HALTED: instr_ready=0, halted=1, bubbles issued, scoreboard keeps draining.
  - HALTED -> RUN on resume=1 at a clock edge. resume in RUN is ignored.
- instr_data may change while stalled. The hazard is recomputed each cycle and no word is latched until transfer.
- rst mid-stall or mid-HALT returns to RUN with an empty scoreboard immediately.

Optional Feature:
- ISSUE_PERF_EN.
- Defined:
  - Adds outputs issue_cnt[15:0], which counts accepted non-bubble instructions (we=1).
  - Adds stall_cnt[15:0], which counts cycles with instr_valid=1 & RUN & hazard.
  - Both counters wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Reset then LDI r3,0x85 -> after the accept edge: we=1, s2ctr=1, rdest_r=3, im16=16'hFF85. Next cycle with no instruction: we=0.
- ADD r1,r2 then independent SUB r4,r5 back-to-back -> both accepted on consecutive edges. aluctr 00 then 01, ra/rb = 1/2 then 4/5, no stall.
- LDI r2,0x01 then ADD r1,r2 (PIPE_DEPTH=2) -> instr_ready=0 for exactly 2 cycles with we=0 bubbles, then ADD issues with aluctr=00, rdest_r=1.
- HALT, then ADD r1,r1 held valid -> halted=1 and instr_ready=0 for 10 cycles. Pulse resume -> ADD accepted on the following edge.
- Opcode 0x9 -> we=0, err_illegal=1 and held. Assert rst mid-stream -> all outputs 0 asynchronously.
- ISSUE_PERF_EN defined: run the third scenario -> issue_cnt=2, stall_cnt=2. Preload 0xFFFF issues then issue one more -> issue_cnt wraps to 0.
